j2c_rx: RTL and testbench
=========================

# j2c_rx

Receive end of the J2C two-wire serial link. It observes the `sda`/`scl` pair driven by the `j2c` transmitter and reconstructs each 8-bit byte. Each complete frame is presented on a parallel output with a one-cycle valid strobe. It sits on the far side of the link, in the same `clk` domain family, and also flags malformed frames.

## Interface
- `MESSAGE_LENGTH`, 8, number of data bits per frame, MSB first.
- `SYNC_STAGES`, 2, synchronizer depth on `sda` and `scl`; minimum 2.

- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `sda`  input  1  serial data line from transmitter.
- `scl`  input  1  serial clock line from transmitter.
- `data_out`  output  MESSAGE_LENGTH  last correctly received byte; holds until the next good frame.
- `data_valid`  output  1  one-`clk` pulse when `data_out` updates.
- `busy`  output  1  high from START detection until the frame ends or is aborted.
- `frame_err`  output  1  one-`clk` pulse on any malformed frame.

## Operation
- Line protocol:
  - Idle is `scl`=1, `sda`=1.
  - START is `sda` 1→0 while `scl`=1.
  - Each bit is sampled on the `scl` 0→1 edge, MSB first.
  - STOP is `sda` 0→1 while `scl`=1.
  - `sda` changes only while `scl`=0, except at START and STOP.
- `sda` and `scl` each pass through `SYNC_STAGES` flops, then one more "previous" flop. Events are decoded from the synchronized value versus the previous value:
  - `scl_rise`
  - `start_ev`: `sda_s` fell with `scl_s`=1.
  - `stop_ev`: `sda_s` rose with `scl_s`=1.
- State machine:
  - IDLE: on `start_ev`, clear bit counter and shift register, go to DATA.
  - DATA: on `scl_rise`, shift `sda_s` into the LSB and increment the counter. When the counter reaches `MESSAGE_LENGTH`, go to PARITY if the parity feature is compiled in, else go to WAIT_STOP.
  - PARITY (macro only): on `scl_rise`, capture the parity bit and go to WAIT_STOP.
  - WAIT_STOP:
    - On `stop_ev` with a good frame: load `data_out` from the shift register, pulse `data_valid`, go to IDLE.
    - On `stop_ev` with a parity failure: pulse `frame_err`, do not update `data_out`, go to IDLE.
    - On `scl_rise` (an extra bit): pulse `frame_err`, go to IDLE.
- Abort conditions:
  - `stop_ev` in DATA or PARITY: pulse `frame_err`, discard the frame, go to IDLE.
  - `start_ev` in DATA, PARITY or WAIT_STOP (repeated start): pulse `frame_err`, restart in DATA with the counter cleared.
  - `stop_ev` or `scl_rise` in IDLE is ignored.
- Evaluation order: `start_ev` and `stop_ev` are mutually exclusive by construction. When an `scl_rise` coincides with `start_ev`/`stop_ev` (both lines moving), the START/STOP takes priority and the bit is not shifted.
- `busy` = (state != IDLE).

## Timing
- Reset (`reset`=0 at a `clk` edge):
  - All synchronizer and previous flops load 1 (idle line).
  - State goes to IDLE; counter, shift register and `data_out` clear to 0.
  - `data_valid`, `frame_err` and `busy` go to 0.
- Reset mid-frame drops the partial frame silently, with no `frame_err`.
- Latency:
  - A pin transition is first visible as an event on the edge `SYNC_STAGES`+1 after it.
  - `data_valid` and the new `data_out` are registered one edge later. With defaults, that is the 4th `clk` rising edge after the STOP transition on the pins.
- `data_valid` and `frame_err` are never high together. Each lasts exactly one cycle.
- Input constraint: each `scl` high and low phase is at least `SYNC_STAGES`+2 `clk` periods. A faster line is out of spec and has undefined results, but must not hang the FSM.
- `data_out` is stable whenever `data_valid`=0.

## Configuration
- `J2C_RX_PARITY_EN`
  - Defined: the frame carries a 9th bit after the data (even parity over data plus parity bit). A mismatch at STOP gives a `frame_err` pulse instead of `data_valid`. The PARITY state exists.
  - Undefined: frames are exactly `MESSAGE_LENGTH` bits. The PARITY state and parity flop are not generated. A 9th `scl_rise` is treated as an extra-bit error.

## Test plan
- Reset hold: `reset`=0 for 3 cycles with lines idle → all outputs 0 and `busy`=0; release → no activity until START.
- Single frame: START, bits 0x5F, STOP → `busy` rises 3 edges after START; `data_out`=0x5F, `data_valid` pulse on the 4th edge after STOP; `frame_err`=0.
- Back-to-back: frames 0x95, 0xF0, 0x0F with minimum idle between them → three `data_valid` pulses carrying those values in order, no `frame_err`.
- Early STOP: START, 5 bits, STOP → one `frame_err` pulse; `data_out` keeps its previous value (0x0F); `busy` returns to 0.
- Repeated start and reset: START, 4 bits, START, 0xA5, STOP → `frame_err` pulse, then `data_valid` with 0xA5. Then `reset`=0 mid-frame → no pulses and `data_out`=0.
- Parity (with `J2C_RX_PARITY_EN`):
  - 0x5F with parity 0 → valid.
  - 0x5F with parity 1 → `frame_err`, `data_out` unchanged.

Source files
------------

// File: rtl/j2c_rx.sv
// j2c_rx: receive end of the J2C two-wire serial link.
// Synchronizes sda/scl, decodes START/STOP/bit events and rebuilds each
// MESSAGE_LENGTH-bit frame (MSB first), flagging malformed frames.
// Optional feature: define J2C_RX_PARITY_EN to expect a trailing even-parity bit.
module j2c_rx #(
  parameter int MESSAGE_LENGTH = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sda,
  input  logic                      scl,
  output logic [MESSAGE_LENGTH-1:0] data_out,
  output logic                      data_valid,
  output logic                      busy,
  output logic                      frame_err
);

  localparam int CW = $clog2(MESSAGE_LENGTH + 1);

`ifdef J2C_RX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_WAIT_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_WAIT_STOP} state_t;
`endif

  logic [SYNC_STAGES-1:0]    sda_sync, scl_sync;
  logic                      sda_s, scl_s, sda_p, scl_p;
  logic                      scl_rise, start_ev, stop_ev;

  state_t                    state, state_d;
  logic [CW-1:0]             cnt, cnt_d;
  logic [MESSAGE_LENGTH-1:0] shreg, shreg_d;
  logic [MESSAGE_LENGTH-1:0] frame_q;
  logic                      load, err, load_q, err_q;
  logic                      par_ok;

`ifdef J2C_RX_PARITY_EN
  logic                      par_q, par_d;
  assign par_ok = ~^{shreg, par_q};
`else
  assign par_ok = 1'b1;
`endif

  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign scl_s = scl_sync[SYNC_STAGES-1];

  // Synchronizer chains plus the previous-value flops; reset to an idle line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sda_sync <= '1;
      scl_sync <= '1;
      sda_p    <= 1'b1;
      scl_p    <= 1'b1;
    end else begin
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_p    <= sda_s;
      scl_p    <= scl_s;
    end
  end

  assign scl_rise = scl_s & ~scl_p;
  assign start_ev = scl_s & sda_p & ~sda_s;
  assign stop_ev  = scl_s & ~sda_p & sda_s;

  // Frame state machine: START/STOP are tested before scl_rise so a bit
  // arriving with a line condition is never shifted.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    shreg_d = shreg;
    load    = 1'b0;
    err     = 1'b0;
`ifdef J2C_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state)
      S_IDLE: begin
        if (start_ev) begin
          state_d = S_DATA;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      S_DATA: begin
        if (start_ev) begin
          err     = 1'b1;
          cnt_d   = '0;
          shreg_d = '0;
        end else if (stop_ev) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end else if (scl_rise) begin
          shreg_d = {shreg[MESSAGE_LENGTH-2:0], sda_s};
          cnt_d   = cnt + 1'b1;
          if (cnt == CW'(MESSAGE_LENGTH - 1)) begin
`ifdef J2C_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_WAIT_STOP;
`endif
          end
        end
      end
`ifdef J2C_RX_PARITY_EN
      S_PARITY: begin
        if (start_ev) begin
          err     = 1'b1;
          state_d = S_DATA;
          cnt_d   = '0;
          shreg_d = '0;
        end else if (stop_ev) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end else if (scl_rise) begin
          par_d   = sda_s;
          state_d = S_WAIT_STOP;
        end
      end
`endif
      S_WAIT_STOP: begin
        if (start_ev) begin
          err     = 1'b1;
          state_d = S_DATA;
          cnt_d   = '0;
          shreg_d = '0;
        end else if (stop_ev) begin
          load    = par_ok;
          err     = ~par_ok;
          state_d = S_IDLE;
        end else if (scl_rise) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, bit counter, shift register and the pending result stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      frame_q <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef J2C_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      shreg  <= shreg_d;
      load_q <= load;
      err_q  <= err;
      if (load) frame_q <= shreg;
`ifdef J2C_RX_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  // Output register: data_out only moves together with a data_valid pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= load_q;
      frame_err  <= err_q;
      if (load_q) data_out <= frame_q;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_j2c_rx.sv
// tb_j2c_rx: randomized bench for j2c_rx against a protocol-level model.
module tb_j2c_rx;

  localparam int ML   = 8;
  localparam int SS   = 2;
  localparam int MAXC = 60000;
`ifdef J2C_RX_PARITY_EN
  localparam int NB = ML + 1;
`else
  localparam int NB = ML;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          sda   = 1'b1;
  logic          scl   = 1'b1;
  logic [ML-1:0] data_out;
  logic          data_valid, busy, frame_err;

  j2c_rx #(.MESSAGE_LENGTH(ML), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .sda(sda), .scl(scl),
    .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int H = 5;

  // expected output timelines, indexed by clock edge
  bit          exp_valid [0:MAXC+7];
  bit          exp_err   [0:MAXC+7];
  bit          exp_busy  [0:MAXC+7];
  bit          exp_rst   [0:MAXC+7];
  bit [ML-1:0] exp_byte  [0:MAXC+7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, req);
    end
  endtask

  // protocol-level model: line samples at each edge decide frame outcomes;
  // results surface 3 edges later (busy 2 edges later)
  bit          seen_reset = 1'b0;
  bit          in_frame   = 1'b0;
  bit          mbits[$];
  logic        ps_sda = 1'b1, ps_scl = 1'b1;
  int          m_valid = 0;
  bit [ML-1:0] m_last = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc > MAXC) begin
      $display("FAIL watchdog cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    if (!reset) begin
      seen_reset = 1'b1;
      in_frame = 1'b0;
      mbits.delete();
      ps_sda = 1'b1;
      ps_scl = 1'b1;
      exp_rst[cyc] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        exp_valid[cyc+i] = 1'b0;
        exp_err[cyc+i]   = 1'b0;
        exp_busy[cyc+i]  = 1'b0;
      end
    end else begin
      bit st, sp, rs;
      st = ps_sda & ~sda & scl;
      sp = ~ps_sda & sda & scl;
      rs = ~ps_scl & scl;
      if (st) begin
        if (in_frame) exp_err[cyc+3] = 1'b1;
        in_frame = 1'b1;
        mbits.delete();
      end else if (sp) begin
        if (in_frame) begin
          int ones = 0;
          foreach (mbits[i]) ones += mbits[i];
          if (mbits.size() == NB && (NB == ML || ones % 2 == 0)) begin
            bit [ML-1:0] b = '0;
            for (int i = 0; i < ML; i++) b = (b << 1) | ML'(mbits[i]);
            exp_valid[cyc+3] = 1'b1;
            exp_byte[cyc+3]  = b;
            m_valid++;
            m_last = b;
          end else begin
            exp_err[cyc+3] = 1'b1;
          end
          in_frame = 1'b0;
        end
      end else if (rs && in_frame) begin
        mbits.push_back(sda);
        if (mbits.size() > NB) begin
          exp_err[cyc+3] = 1'b1;
          in_frame = 1'b0;
        end
      end
      exp_busy[cyc+2] = in_frame;
      ps_sda = sda;
      ps_scl = scl;
    end
  end

  // compare process plus bookkeeping of what the DUT actually produced
  bit [ML-1:0] shown = '0;
  int          n_valid = 0, n_err = 0;
  int          last_valid_cyc = 0, busy_rise_cyc = 0;
  bit          prev_busy = 1'b0;
  bit [ML-1:0] last_byte = '0;
  bit [ML-1:0] vlog[$];

  always @(negedge clk) begin
    if (seen_reset) begin
      if (exp_rst[cyc]) shown = '0;
      else if (exp_valid[cyc]) shown = exp_byte[cyc];
      chk("data_valid", 32'(data_valid), 32'(exp_valid[cyc]));
      chk("frame_err", 32'(frame_err), 32'(exp_err[cyc]));
      chk("busy", 32'(busy), 32'(exp_busy[cyc]));
      chk("data_out", 32'(data_out), 32'(shown));
      if (data_valid === 1'b1) begin
        n_valid++;
        last_byte = data_out;
        last_valid_cyc = cyc;
        vlog.push_back(data_out);
      end
      if (frame_err === 1'b1) n_err++;
      if (busy === 1'b1 && !prev_busy) busy_rise_cyc = cyc;
      prev_busy = (busy === 1'b1);
    end
  end

  // ---------------- line driver (all changes on falling clk edges)
  int start_cyc = 0, stop_cyc = 0;

  task automatic drive(input logic d, input logic c);
    sda = d;
    scl = c;
    repeat (H) @(negedge clk);
  endtask

  task automatic idle(input int n);
    sda = 1'b1;
    scl = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cond();
    start_cyc = cyc;
    drive(1'b0, 1'b1);
  endtask

  task automatic send_bit(input logic b);
    drive(sda, 1'b0);
    drive(b, 1'b0);
    drive(b, 1'b1);
  endtask

  task automatic stop_cond();
    drive(sda, 1'b0);
    drive(1'b0, 1'b0);
    stop_cyc = cyc;
    drive(1'b1, 1'b1);
  endtask

  task automatic restart_cond();
    drive(sda, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    start_cyc = cyc;
    drive(1'b0, 1'b1);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  function automatic logic [15:0] word(input logic [ML-1:0] d, input logic bad);
`ifdef J2C_RX_PARITY_EN
    return {7'b0, d, (^d) ^ bad};
`else
    return {8'b0, d} ^ 16'(bad);
`endif
  endfunction

  task automatic frame(input logic [ML-1:0] d, input logic bad);
    start_cond();
    send_bits(word(d, bad), NB);
    stop_cond();
  endtask

  initial begin
    // reset hold, lines idle
    @(negedge clk);
    repeat (2) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    idle(10);

    // single frame with latency pins
    frame(8'h5F, 1'b0);
    idle(8);
    chk("single_nvalid", n_valid, 1);
    chk("single_byte", 32'(last_byte), 32'h5F);
    chk("single_nerr", n_err, 0);
    chk("stop_to_valid", last_valid_cyc - stop_cyc, 4);
    chk("start_to_busy", busy_rise_cyc - start_cyc, 3);
    chk("model_byte", 32'(m_last), 32'h5F);

    // back-to-back at minimum phase / idle
    H = SS + 2;
    frame(8'h95, 1'b0); idle(SS + 2);
    frame(8'hF0, 1'b0); idle(SS + 2);
    frame(8'h0F, 1'b0); idle(8);
    H = 5;
    chk("b2b_nvalid", n_valid, 4);
    chk("b2b_0", 32'(vlog[1]), 32'h95);
    chk("b2b_1", 32'(vlog[2]), 32'hF0);
    chk("b2b_2", 32'(vlog[3]), 32'h0F);
    chk("b2b_nerr", n_err, 0);

    // early stop
    start_cond();
    send_bits(16'h0015, 5);
    stop_cond();
    idle(8);
    chk("early_nerr", n_err, 1);
    chk("early_keep", 32'(data_out), 32'h0F);
    chk("early_busy", 32'(busy), 32'h0);

    // repeated start then a good frame
    start_cond();
    send_bits(16'h000A, 4);
    restart_cond();
    send_bits(word(8'hA5, 1'b0), NB);
    stop_cond();
    idle(8);
    chk("rs_nerr", n_err, 2);
    chk("rs_nvalid", n_valid, 5);
    chk("rs_byte", 32'(last_byte), 32'hA5);

    // reset mid-frame drops it silently
    start_cond();
    send_bits(16'h0005, 3);
    reset = 1'b0;
    sda = 1'b1;
    scl = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(8);
    chk("mrst_nerr", n_err, 2);
    chk("mrst_data", 32'(data_out), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);

    // good frame, then a corrupted one (bad parity, or one extra bit)
    frame(8'h5F, 1'b0);
    idle(6);
`ifdef J2C_RX_PARITY_EN
    frame(8'h5F, 1'b1);
`else
    start_cond();
    send_bits({7'b0, 8'h5F, 1'b0}, NB + 1);
    stop_cond();
`endif
    idle(8);
    chk("bad_nvalid", n_valid, 6);
    chk("bad_nerr", n_err, 3);
    chk("bad_keep", 32'(data_out), 32'h5F);

    // randomized frames and faults
    for (int f = 0; f < 150; f++) begin
      int kind, k;
      logic [ML-1:0] d;
      H = $urandom_range(SS + 2, SS + 4);
      d = ML'($urandom);
      kind = $urandom_range(0, 9);
      case (kind)
        6: begin
          start_cond();
          k = $urandom_range(1, NB - 1);
          send_bits(16'($urandom), k);
          stop_cond();
        end
        7: begin
          start_cond();
          send_bits(16'($urandom), NB + 1);
          stop_cond();
        end
        8: begin
          start_cond();
          k = $urandom_range(0, NB);
          send_bits(16'($urandom), k);
          restart_cond();
          send_bits(word(d, 1'b0), NB);
          stop_cond();
        end
        9: frame(d, 1'($urandom));
        default: frame(d, 1'b0);
      endcase
      idle($urandom_range(SS + 2, 10));
    end
    idle(10);
    chk("total_valid", n_valid, m_valid);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
